// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST sequencer: FSM state encoding,
// default LFSR/CRC polynomials and the MSB-first CRC step.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC_REQ,
        CALC_WAIT,
        TEST_INIT,
        TEST_REQ,
        TEST_WAIT,
        TEST_FOLD,
        TEST_DONE
    } bist_state_e;

    localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;
    localparam logic [7:0] CRC_POLY_DEFAULT  = 8'h07;

    // Operates on the low 'width' bits (width <= 32); the polynomial excludes the implicit top bit.
    function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                             input logic [31:0] data,
                                             input logic [31:0] poly,
                                             input int          width);
        logic [31:0] mask;
        logic [31:0] msb;
        logic [31:0] c;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        msb  = 32'd1 << (width - 1);
        c    = (crc ^ data) & mask;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                if ((c & msb) != '0) c = ((c << 1) ^ poly) & mask;
                else                 c = (c << 1) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/bist_sequencer_if.sv
// Start/busy handshake between the sequencer (master) and the arithmetic unit (slave).
interface bist_sequencer_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              dut_start;
    logic [DATA_W-1:0] dut_x;
    logic              dut_busy;
    logic [DATA_W-1:0] dut_result;

    modport master (output dut_start, output dut_x, input dut_busy, input dut_result);
    modport slave  (input dut_start, input dut_x, output dut_busy, output dut_result);
endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR vector source: shifts toward the MSB, parity of tapped bits enters the LSB.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(LFSR_TAPS_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic [DATA_W-1:0] state_o
);
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic              fb;

    always_comb begin
        fb     = ^(lfsr_q & LFSR_TAPS);
        lfsr_d = lfsr_q;
        if (load_i) begin
            // An all-zero state would lock up the register.
            lfsr_d = (seed_i == '0) ? '1 : seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[DATA_W-2:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= '1;
        else     lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;
endmodule

// File: rtl/bist_sequencer.sv
// Calc / self-test front end for a start/busy arithmetic unit. Optional build macro
// BIST_GOLDEN_CHECK_EN compares the final signature with golden_sig_i.
//   state     | meaning
//   IDLE      | waiting for a calc or test request
//   CALC_REQ  | dut_start high with latched operand until unit reports busy
//   CALC_WAIT | unit running, capture result when busy drops
//   TEST_INIT | load seed, clear signature, vector count and verdict
//   TEST_REQ  | dut_start high with current LFSR vector
//   TEST_WAIT | unit running on a test vector
//   TEST_FOLD | fold result into signature, advance LFSR and vector count
//   TEST_DONE | count the test and publish the verdict
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       N_VECTORS = 256,
    parameter int unsigned       CNT_W     = 4,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(LFSR_TAPS_DEFAULT),
    parameter logic [DATA_W-1:0] CRC_POLY  = DATA_W'(CRC_POLY_DEFAULT),
    parameter int unsigned       TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_calc_i,
    input  logic              start_stop_test_i,
    input  logic              seed_from_data_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic [DATA_W-1:0] golden_sig_i,
    bist_sequencer_if.master  dut,
    output logic              busy_o,
    output logic [CNT_W-1:0]  test_count_o,
    output logic [DATA_W-1:0] result_o,
    output logic              pass_o,
    output logic              fail_o
);
    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    bist_state_e       state_q, state_d;
    logic              calc_prev_q, test_prev_q, calc_edge_q, test_edge_q;
    logic              busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
    logic [CNT_W-1:0]  tc_q, tc_d;
    logic [DATA_W-1:0] result_q, result_d, crc_q, crc_d, x_q, x_d;
    logic [DATA_W-1:0] crc_next, lfsr_state, seed;
    logic [15:0]       vcnt_q, vcnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              lfsr_load, lfsr_step, is_test, timeout_hit, verdict_pass;

    assign is_test     = state_q inside {TEST_INIT, TEST_REQ, TEST_WAIT, TEST_FOLD, TEST_DONE};
    assign timeout_hit = (TIMEOUT != 0) && (tmr_q <= TMR_W'(1));
    assign seed        = seed_from_data_i ? data_in_i : '1;
    assign crc_next    = DATA_W'(crc_step(32'(crc_q), 32'(dut.dut_result), 32'(CRC_POLY), DATA_W));

`ifdef BIST_GOLDEN_CHECK_EN
    assign verdict_pass = (crc_q == golden_sig_i);
`else
    logic unused_golden;
    assign unused_golden = ^golden_sig_i;
    assign verdict_pass  = 1'b1;
`endif

    bist_lfsr #(.DATA_W(DATA_W), .LFSR_TAPS(LFSR_TAPS)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (seed),
        .state_o (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tc_d      = tc_q;
        result_d  = result_q;
        crc_d     = crc_q;
        x_d       = x_q;
        vcnt_d    = vcnt_q;
        tmr_d     = tmr_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        // One timer spans a whole request/wait phase, starting when the phase is entered.
        if ((state_q inside {CALC_REQ, CALC_WAIT, TEST_INIT, TEST_REQ, TEST_WAIT}) && (tmr_q != '0))
            tmr_d = tmr_q - TMR_W'(1);

        case (state_q)
            IDLE: begin
                if (test_edge_q) begin
                    state_d = TEST_INIT;
                    busy_d  = 1'b1;
                    tmr_d   = TMR_W'(TIMEOUT);
                end else if (calc_edge_q) begin
                    state_d = CALC_REQ;
                    busy_d  = 1'b1;
                    x_d     = data_in_i;
                    tmr_d   = TMR_W'(TIMEOUT);
                end
            end
            CALC_REQ: begin
                if (dut.dut_busy) begin
                    state_d = CALC_WAIT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            CALC_WAIT: begin
                if (!dut.dut_busy) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    result_d = dut.dut_result;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            TEST_INIT: begin
                state_d   = TEST_REQ;
                lfsr_load = 1'b1;
                crc_d     = '0;
                vcnt_d    = 16'(N_VECTORS);
                pass_d    = 1'b0;
                fail_d    = 1'b0;
            end
            TEST_REQ: begin
                if (dut.dut_busy) begin
                    state_d = TEST_WAIT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                end
            end
            TEST_WAIT: begin
                if (!dut.dut_busy) begin
                    state_d = TEST_FOLD;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                end
            end
            TEST_FOLD: begin
                crc_d     = crc_next;
                result_d  = crc_next;
                lfsr_step = 1'b1;
                vcnt_d    = vcnt_q - 16'd1;
                tmr_d     = TMR_W'(TIMEOUT);
                state_d   = (vcnt_q == 16'd1) ? TEST_DONE : TEST_REQ;
            end
            TEST_DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tc_d    = tc_q + CNT_W'(1);
                pass_d  = verdict_pass;
                fail_d  = !verdict_pass;
            end
            default: state_d = IDLE;
        endcase

        if (is_test && test_edge_q) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            result_d  = '0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            tc_d      = tc_q;
            lfsr_load = 1'b0;
            lfsr_step = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            calc_prev_q <= 1'b0;
            test_prev_q <= 1'b0;
            calc_edge_q <= 1'b0;
            test_edge_q <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            tc_q        <= '0;
            result_q    <= '0;
            crc_q       <= '0;
            x_q         <= '0;
            vcnt_q      <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            calc_prev_q <= start_calc_i;
            test_prev_q <= start_stop_test_i;
            calc_edge_q <= start_calc_i & ~calc_prev_q;
            test_edge_q <= start_stop_test_i & ~test_prev_q;
            busy_q      <= busy_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tc_q        <= tc_d;
            result_q    <= result_d;
            crc_q       <= crc_d;
            x_q         <= x_d;
            vcnt_q      <= vcnt_d;
            tmr_q       <= tmr_d;
        end
    end

    assign dut.dut_start = (state_q == CALC_REQ) || (state_q == TEST_REQ);
    assign dut.dut_x     = is_test ? lfsr_state : x_q;
    assign busy_o        = busy_q;
    assign test_count_o  = tc_q;
    assign result_o      = result_q;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
endmodule

// File: tb/tb_bist_sequencer.sv
// Directed/randomised bench for bist_sequencer with a cube-root unit model and a
// high-level signature reference (LFSR vectors -> cube root -> CRC-8 long division).
`timescale 1ns/1ps
module tb_bist_sequencer;
    localparam int DW = 8;
    localparam int NV = 4;
    localparam int CW = 2;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_calc = 1'b0;
    logic          start_stop = 1'b0;
    logic          seed_sel = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] golden = '0;
    logic          busy;
    logic [CW-1:0] tcount;
    logic [DW-1:0] result;
    logic          pass;
    logic          fail;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bist_sequencer_if #(.DATA_W(DW)) dif ();

    bist_sequencer #(.DATA_W(DW), .N_VECTORS(NV), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_calc_i      (start_calc),
        .start_stop_test_i (start_stop),
        .seed_from_data_i  (seed_sel),
        .data_in_i         (data_in),
        .golden_sig_i      (golden),
        .dut               (dif),
        .busy_o            (busy),
        .test_count_o      (tcount),
        .result_o          (result),
        .pass_o            (pass),
        .fail_o            (fail)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_cbrt(input logic [7:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(x)) r++;
        return 8'(r);
    endfunction

    function automatic logic [7:0] ref_lfsr_next(input logic [7:0] s);
        logic [7:0] t;
        int ones = 0;
        t = 8'hB8;
        for (int i = 0; i < 8; i++) if (t[i] && s[i]) ones++;
        return {s[6:0], 1'(ones % 2)};
    endfunction

    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
        logic [8:0] r;
        r = {1'b0, c ^ d};
        repeat (8) begin
            r = r << 1;
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] ref_sig(input logic [7:0] seed_v, input int n);
        logic [7:0] s;
        logic [7:0] c;
        s = (seed_v == 8'h00) ? 8'hFF : seed_v;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = ref_crc(c, ref_cbrt(s));
            s = ref_lfsr_next(s);
        end
        return c;
    endfunction

    // Arithmetic unit model: busy five cycles counted from the dut_start cycle.
    logic       stuck = 1'b0;
    logic [2:0] ucnt;
    logic [7:0] ux;
    int         done_cnt = 0;
    always_ff @(posedge clk) begin
        if (rst) begin
            dif.dut_busy   <= 1'b0;
            dif.dut_result <= '0;
            ucnt           <= '0;
            ux             <= '0;
        end else if (stuck) begin
            dif.dut_busy <= 1'b1;
            ucnt         <= 3'd3;
        end else if (!dif.dut_busy) begin
            if (dif.dut_start) begin
                dif.dut_busy <= 1'b1;
                ucnt         <= 3'd3;
                ux           <= dif.dut_x;
            end
        end else if (ucnt == 3'd0) begin
            dif.dut_busy   <= 1'b0;
            dif.dut_result <= ref_cbrt(ux);
            done_cnt       <= done_cnt + 1;
        end else begin
            ucnt <= ucnt - 3'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        tick();
        tick();
        k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_unit_idle(input string tag);
        int k;
        k = 0;
        while (dif.dut_busy && k < 100) begin
            tick();
            k++;
        end
        check(tag, 32'(dif.dut_busy), 32'd0);
    endtask

    task automatic do_test(input string tag, input logic sel, input logic [7:0] d,
                           input logic [7:0] gx, input logic [CW-1:0] exp_tc);
        logic [7:0] sig;
        logic       exp_pass;
        sig      = ref_sig(sel ? d : 8'hFF, NV);
        seed_sel = sel;
        data_in  = d;
        golden   = sig ^ gx;
`ifdef BIST_GOLDEN_CHECK_EN
        exp_pass = (gx == 8'h00);
`else
        exp_pass = 1'b1;
`endif
        start_stop = 1'b1;
        wait_idle({tag, "_done"});
        start_stop = 1'b0;
        check({tag, "_result"}, 32'(result), 32'(sig));
        check({tag, "_count"}, 32'(tcount), 32'(exp_tc));
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check({tag, "_fail"}, 32'(fail), 32'(!exp_pass));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         rises;
        int         fall_at;
        int         first_start;
        int         k;
        int         d0;
        logic       prev_b;
        logic [7:0] x;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_count", 32'(tcount), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_dut_start", 32'(dif.dut_start), 32'd0);
        check("rst_dut_x", 32'(dif.dut_x), 32'd0);

        // Calc 27: timing of busy and dut_start relative to the request edge.
        data_in     = 8'd27;
        start_calc  = 1'b1;
        rises       = 0;
        fall_at     = -1;
        first_start = -1;
        prev_b      = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (busy && !prev_b) rises++;
            if (!busy && prev_b && fall_at < 0) fall_at = i;
            if (dif.dut_start && first_start < 0) first_start = i;
            prev_b = busy;
        end
        start_calc = 1'b0;
        check("calc27_result", 32'(result), 32'd3);
        check("calc27_busy_rises", 32'(rises), 32'd1);
        check("calc27_busy_fall", 32'(fall_at), 32'd8);
        check("calc27_first_start", 32'(first_start), 32'd2);
        tick();

        for (int i = 0; i < 3; i++) begin
            x          = 8'($urandom_range(0, 255));
            data_in    = x;
            start_calc = 1'b1;
            wait_idle("calc_rand_done");
            start_calc = 1'b0;
            check("calc_rand_result", 32'(result), 32'(ref_cbrt(x)));
            tick();
        end

        do_test("test_good", 1'b0, 8'($urandom), 8'h00, 2'd1);
        do_test("test_badgold", 1'b1, 8'($urandom_range(1, 255)), 8'h01, 2'd2);

        // Abort after two vectors, with a calc request landing mid-test.
        seed_sel   = 1'b0;
        start_stop = 1'b1;
        tick();
        tick();
        start_stop = 1'b0;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt < d0 + 2 && k < 200) begin
            tick();
            k++;
        end
        check("abort_two_vectors", 32'(done_cnt - d0), 32'd2);
        tick();
        tick();
        start_calc = 1'b1;
        tick();
        tick();
        start_calc = 1'b0;
        check("abort_still_busy", 32'(busy), 32'd1);
        start_stop = 1'b1;
        tick();
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_count", 32'(tcount), 32'd2);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_fail", 32'(fail), 32'd0);
        start_stop = 1'b0;
        repeat (6) tick();
        check("abort_calc_not_queued", 32'(busy), 32'd0);
        wait_unit_idle("abort_unit_idle");
        tick();

        // Unit stuck busy: timeout ends the test with fail.
        stuck = 1'b1;
        tick();
        start_stop = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 21) check("timeout_busy_before", 32'(busy), 32'd1);
        end
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_fail", 32'(fail), 32'd1);
        check("timeout_pass", 32'(pass), 32'd0);
        check("timeout_count", 32'(tcount), 32'd2);
        start_stop = 1'b0;
        stuck      = 1'b0;
        tick();
        wait_unit_idle("timeout_unit_idle");
        tick();

        do_test("test_wrap3", 1'b1, 8'h00, 8'h00, 2'd3);
        do_test("test_wrap0", 1'b1, 8'($urandom_range(1, 255)), 8'h00, 2'd0);

        // Reset while the unit is running a test vector.
        seed_sel   = 1'b0;
        start_stop = 1'b1;
        k = 0;
        while (!(dif.dut_busy && busy) && k < 40) begin
            tick();
            k++;
        end
        check("rstwait_reached", 32'(dif.dut_busy), 32'd1);
        tick();
        rst        = 1'b1;
        start_stop = 1'b0;
        tick();
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_result", 32'(result), 32'd0);
        check("rstmid_count", 32'(tcount), 32'd0);
        check("rstmid_pass", 32'(pass), 32'd0);
        check("rstmid_fail", 32'(fail), 32'd0);
        check("rstmid_dut_start", 32'(dif.dut_start), 32'd0);
        check("rstmid_dut_x", 32'(dif.dut_x), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        do_test("test_after_rst", 1'b1, 8'($urandom), 8'h00, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bist_sequencer.md
# bist_sequencer

Parametrised controller that fronts an iterative arithmetic unit (the cube-root core or any start/busy unit of the same shape) with two modes: single calculation on operand data, and built-in self-test. Self-test drives the unit with an internal LFSR vector stream, folds every result into a CRC signature and optionally compares it with a golden value. It is the next generation of the lab control logic: width, vector count, polynomials and timeout are generic, a test can be aborted, and pass/fail is reported.

## Interface
- DATA_W, 8: operand, result, LFSR and CRC width.
- N_VECTORS, 256: vectors per test run (1..65535).
- CNT_W, 4: width of completed-test counter.
- LFSR_TAPS, 8'hB8: Fibonacci feedback mask (DATA_W bits).
- CRC_POLY, 8'h07: CRC polynomial (DATA_W bits, implicit MSB), init 0, MSB-first, no reflection, no final XOR.
- TIMEOUT, 1023: max cycles waiting on dut_busy in any phase; 0 disables.
- clk in 1: clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- start_calc in 1: level; rising edge requests one calculation.
- start_stop_test in 1: level; rising edge starts a test, or aborts one in progress.
- seed_from_data in 1: sampled at test start; 1 = seed from data_in, 0 = all-ones seed.
- data_in in DATA_W: operand / seed.
- golden_sig in DATA_W: expected signature, sampled at TEST_DONE.
- dut_start out 1, dut_x out DATA_W: request and operand to the arithmetic unit.
- dut_busy in 1, dut_result in DATA_W: unit status and result.
- busy out 1: any mode active.
- test_count out CNT_W: completed (non-aborted) tests, wraps to 0.
- result out DATA_W: last calc result or current/final signature.
- pass out 1, fail out 1: test verdict, held until next test starts or reset.

## Operation
- Reset: all outputs 0; state IDLE; LFSR = all-ones; CRC = 0; edge detectors' previous-value registers = 0.
- States: IDLE, CALC_REQ, CALC_WAIT, TEST_INIT, TEST_REQ, TEST_WAIT, TEST_FOLD, TEST_DONE.
- IDLE: test edge -> TEST_INIT; else calc edge -> CALC_REQ (test wins on simultaneous edges). busy=1 from the following cycle.
- CALC_REQ: dut_x=data_in (latched on entry), dut_start=1 until dut_busy=1 seen, then CALC_WAIT with dut_start=0.
- CALC_WAIT: on dut_busy=0, result<=dut_result, busy<=0, IDLE.
- TEST_INIT: load seed (zero seed replaced by all-ones), CRC<=0, vector counter<=N_VECTORS, pass/fail<=0 -> TEST_REQ.
- TEST_REQ/TEST_WAIT: as calc handshake with dut_x=LFSR state.
- TEST_FOLD: one cycle; CRC<=crc_step(CRC, dut_result); result<=new CRC; LFSR steps; counter decrements; counter reaching 0 -> TEST_DONE, else TEST_REQ.
- TEST_DONE: test_count increments; pass/fail per Configuration; busy<=0; IDLE.
- calc edges while busy are ignored and not queued; test edge while testing aborts: dut_start<=0, busy<=0, result<=0, pass=fail=0, test_count unchanged, IDLE. Abort does not reset the arithmetic unit.
- Timeout in any wait: dut_start<=0, fail<=1 (test mode only), busy<=0, IDLE.
- rst mid-operation has priority over everything, same values as reset.

## Timing
- Edge detection adds 1 cycle; first dut_start at cycle 2 after the input edge.
- Per vector: handshake + unit latency + 1 fold cycle.
- result, pass, fail, test_count update together on the cycle busy falls.

## Configuration
- BIST_GOLDEN_CHECK_EN defined: at TEST_DONE pass=(CRC==golden_sig), fail=!pass.
- Undefined: golden_sig unused, pass forced 1 at TEST_DONE, fail only set by timeout.

## Structure
- Package bist_pkg: state enum, default LFSR_TAPS and CRC_POLY constants, crc_step function.
- Sub-module bist_lfsr (load, step, seed, state), parameterised by DATA_W and LFSR_TAPS.

## Test plan
- Calc: DUT model floor cube root with 5-cycle latency, data_in=27 edge -> result=3, busy high exactly once, falls 8 cycles after edge.
- Test, N_VECTORS=4, seed_from_data=0, golden from reference model -> pass=1, fail=0, test_count 0->1, result=golden.
- Same with golden_sig XOR 1 under BIST_GOLDEN_CHECK_EN -> pass=0, fail=1; without macro -> pass=1.
- Abort after 2 vectors -> busy=0, result=0, test_count unchanged; calc edge in mid-test ignored.
- DUT holds busy=1 forever, TIMEOUT=20 -> fail=1, busy=0 at 22 cycles after edge.
- CNT_W=2, 4 completed tests -> test_count wraps to 0; rst during TEST_WAIT -> all outputs 0 next cycle.
